fourand_stim_gen: RTL and testbench

//  Clocked stimulus sequencer sitting directly upstream of the fourand gate block.

---
 rtl/fourand_stim_gen.sv | 160 ++++++++++++++++
 tb/tb_fourand_stim_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fourand_stim_gen.sv
// -----------------------------------------------------------------------------
// fourand_stim_gen
//   Clocked stimulus sequencer for the fourand gate block. While running it
//   produces one "tick" every TICK_DIV clocks. It toggles a on every tick,
//   b on every 2nd tick and c on every 3rd tick. After RUN_TICKS ticks it
//   stops and reports done.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   begin a run (level or pulse); ignored while running
//   stop      in   abort the run / leave DONE; wins over start
//   a, b, c   out  stimulus to fourand .a/.b/.c (registered)
//   busy      out  high while in RUN (registered)
//   done      out  high while in DONE (registered)
//   tick_cnt  out  ticks completed in the current or last run
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; outputs and counters cleared
// RUN   | dividing clk into ticks and toggling a/b/c
// DONE  | RUN_TICKS ticks completed; a/b/c and tick_cnt held
// -----------------------------------------------------------------------------
module fourand_stim_gen #(
    parameter int TICK_DIV  = 50,
    parameter int RUN_TICKS = 20,
    localparam int CW = $clog2(RUN_TICKS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    output logic          a,
    output logic          b,
    output logic          c,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] tick_cnt
);

    // With TICK_DIV == 1 the divider only ever holds 0, but it still needs one bit.
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] div, div_nxt;
    logic          m2, m2_nxt;
    logic [1:0]    m3, m3_nxt;
    logic          a_nxt, b_nxt, c_nxt;
    logic [CW-1:0] tick_cnt_nxt;
    logic          busy_nxt, done_nxt;
    logic          clr;
    logic          tick;

    assign tick = (div == DW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            div      <= '0;
            m2       <= 1'b0;
            m3       <= 2'd0;
            a        <= 1'b0;
            b        <= 1'b0;
            c        <= 1'b0;
            tick_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            div      <= div_nxt;
            m2       <= m2_nxt;
            m3       <= m3_nxt;
            a        <= a_nxt;
            b        <= b_nxt;
            c        <= c_nxt;
            tick_cnt <= tick_cnt_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        div_nxt      = div;
        m2_nxt       = m2;
        m3_nxt       = m3;
        a_nxt        = a;
        b_nxt        = b;
        c_nxt        = c;
        tick_cnt_nxt = tick_cnt;
        clr          = 1'b0;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt = RUN;
                    clr       = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    // a tick due on this edge is discarded along with the run
                    state_nxt = IDLE;
                    clr       = 1'b1;
                end else if (tick) begin
                    div_nxt      = '0;
                    a_nxt        = ~a;
                    m2_nxt       = ~m2;
                    // new m2 is 0 exactly when the old one was 1
                    if (m2)
                        b_nxt = ~b;
                    if (m3 == 2'd2) begin
                        m3_nxt = 2'd0;
                        c_nxt  = ~c;
                    end else begin
                        m3_nxt = m3 + 2'd1;
                    end
                    tick_cnt_nxt = tick_cnt + CW'(1);
                    if (tick_cnt == CW'(RUN_TICKS - 1))
                        state_nxt = DONE;
                end else begin
                    div_nxt = div + DW'(1);
                end
            end
            DONE: begin
                if (stop) begin
                    state_nxt = IDLE;
                    clr       = 1'b1;
                end else if (start) begin
                    state_nxt = RUN;
                    clr       = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                clr       = 1'b1;
            end
        endcase

        if (clr) begin
            div_nxt      = '0;
            m2_nxt       = 1'b0;
            m3_nxt       = 2'd0;
            a_nxt        = 1'b0;
            b_nxt        = 1'b0;
            c_nxt        = 1'b0;
            tick_cnt_nxt = '0;
        end

        busy_nxt = (state_nxt == RUN);
        done_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_fourand_stim_gen.sv
// -----------------------------------------------------------------------------
// tb_fourand_stim_gen
//   Two instances: (TICK_DIV=4, RUN_TICKS=6) and (TICK_DIV=1, RUN_TICKS=3).
//   The reference model tracks each run as "clocks since start". It derives the
//   tick count from that, and derives a/b/c as parities of k, k/2 and k/3.
// -----------------------------------------------------------------------------
module tb_fourand_stim_gen;

    localparam int TD0 = 4;
    localparam int RT0 = 6;
    localparam int TD1 = 1;
    localparam int RT1 = 3;
    localparam int CW0 = $clog2(RT0 + 1);
    localparam int CW1 = $clog2(RT1 + 1);

    logic clk = 1'b0;
    logic rst;
    logic start0, stop0, start1, stop1;
    logic a0, b0, c0, busy0, done0;
    logic a1, b1, c1, busy1, done1;
    logic [CW0-1:0] tick_cnt0;
    logic [CW1-1:0] tick_cnt1;

    int checks   = 0;
    int failures = 0;

    // model: 0 idle, 1 run, 2 done
    int m_state[2];
    int m_cyc[2];
    int m_k[2];
    int td[2];
    int rt[2];

    always #5 clk = ~clk;

    fourand_stim_gen #(.TICK_DIV(TD0), .RUN_TICKS(RT0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .stop(stop0),
        .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0), .tick_cnt(tick_cnt0)
    );

    fourand_stim_gen #(.TICK_DIV(TD1), .RUN_TICKS(RT1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .stop(stop1),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .tick_cnt(tick_cnt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0;
            m_cyc[i]   = 0;
            m_k[i]     = 0;
        end
    endfunction

    function automatic void model_edge(input int i, input logic s, input logic p);
        if (p) begin
            m_state[i] = 0;
            m_cyc[i]   = 0;
            m_k[i]     = 0;
        end else if (m_state[i] != 1 && s) begin
            m_state[i] = 1;
            m_cyc[i]   = 0;
            m_k[i]     = 0;
        end else if (m_state[i] == 1) begin
            m_cyc[i]++;
            if (m_cyc[i] % td[i] == 0) begin
                m_k[i] = m_cyc[i] / td[i];
                if (m_k[i] == rt[i])
                    m_state[i] = 2;
            end
        end
    endfunction

    function automatic logic [2:0] exp_abc(input int k);
        return {1'((k / 3) % 2), 1'((k / 2) % 2), 1'(k % 2)};
    endfunction

    task automatic compare_all();
        check("abc0",  {29'd0, c0, b0, a0}, {29'd0, exp_abc(m_k[0])});
        check("busy0", {31'd0, busy0}, (m_state[0] == 1) ? 32'd1 : 32'd0);
        check("done0", {31'd0, done0}, (m_state[0] == 2) ? 32'd1 : 32'd0);
        check("tcnt0", 32'(tick_cnt0), 32'(m_k[0]));
        check("abc1",  {29'd0, c1, b1, a1}, {29'd0, exp_abc(m_k[1])});
        check("busy1", {31'd0, busy1}, (m_state[1] == 1) ? 32'd1 : 32'd0);
        check("done1", {31'd0, done1}, (m_state[1] == 2) ? 32'd1 : 32'd0);
        check("tcnt1", 32'(tick_cnt1), 32'(m_k[1]));
    endtask

    // drive inputs, let the next rising edge sample them, then check at +1
    task automatic step(input logic s0, input logic p0, input logic s1, input logic p1);
        start0 = s0; stop0 = p0; start1 = s1; stop1 = p1;
        @(posedge clk);
        #1;
        model_edge(0, s0, p0);
        model_edge(1, s1, p1);
        compare_all();
    endtask

    task automatic mid_cycle_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0] seq0 [6];
        logic [2:0] seq1 [3];
        seq0 = '{3'b001, 3'b010, 3'b111, 3'b100, 3'b101, 3'b010};
        seq1 = '{3'b001, 3'b010, 3'b111};
        td = '{TD0, TD1};
        rt = '{RT0, RT1};

        rst = 1'b1;
        start0 = 1'b0; stop0 = 1'b0; start1 = 1'b0; stop1 = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // full run: edge 0 samples start, then check against the literal sequences
        step(1, 0, 1, 0);
        for (int e = 1; e <= 30; e++) begin
            step(0, 0, 0, 0);
            if (e % 4 == 0 && e <= 24)
                check("seq0", {29'd0, c0, b0, a0}, {29'd0, seq0[e / 4 - 1]});
            if (e <= 3)
                check("seq1", {29'd0, c1, b1, a1}, {29'd0, seq1[e - 1]});
            if (e == 23)
                check("busy0_e23", {31'd0, busy0}, 32'd1);
            if (e == 24) begin
                check("done0_e24", {31'd0, done0}, 32'd1);
                check("tcnt0_e24", 32'(tick_cnt0), 32'd6);
            end
        end

        // DONE with start and stop together -> IDLE, then a fresh run
        step(1, 1, 1, 1);
        check("abc0_idle", {29'd0, c0, b0, a0}, 32'd0);
        step(1, 0, 1, 0);
        repeat (26) step(0, 0, 0, 0);

        // leave DONE, then start again and stop at edge 13
        step(0, 1, 0, 1);
        step(1, 0, 1, 0);
        repeat (12) step(0, 0, 0, 0);
        step(0, 1, 0, 1);
        check("stop_busy0", {31'd0, busy0}, 32'd0);
        repeat (10) step(0, 0, 0, 0);

        // start re-pulsed at edges 5 and 9
        step(1, 0, 1, 0);
        for (int e = 1; e <= 26; e++)
            step((e == 5 || e == 9), 0, (e == 5 || e == 9), 0);
        check("repulse_done0", {31'd0, done0}, 32'd1);

        // async reset between edges, at tick 3 (abc=111)
        step(0, 1, 0, 1);
        step(1, 0, 0, 0);
        repeat (12) step(0, 0, 0, 0);
        check("pre_rst_abc0", {29'd0, c0, b0, a0}, 32'd7);
        mid_cycle_reset();
        step(0, 0, 0, 0);

        // randomized traffic with occasional mid-cycle resets
        for (int n = 0; n < 2500; n++) begin
            step(($urandom_range(7) == 0), ($urandom_range(39) == 0),
                 ($urandom_range(5) == 0), ($urandom_range(29) == 0));
            if ($urandom_range(299) == 0)
                mid_cycle_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
